// File: rtl/aes_pkg.sv
//==============================================================================
// Module   : aes_pkg
// Brief    : Shared AES state/byte types, FSM encodings and byte addressing.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package aes_pkg;

    typedef logic [0:127] aes_state_t;
    typedef logic [0:7]   aes_byte_t;

    localparam int NUM_STATE_BYTES = 16;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t c_st_idle = 2'd0;
    localparam fsm_state_t c_st_busy = 2'd1;
    localparam fsm_state_t c_st_done = 2'd2;

    // First bit of byte 'index' in an aes_state_t; use with '+: 8'.
    function automatic logic [6:0] byte_slice(input logic [3:0] index);
        return {index, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_sbox.sv
//==============================================================================
// Module   : inv_sbox
// Brief    : Combinational FIPS-197 inverse S-box, 8-bit in / 8-bit out.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module inv_sbox
    import aes_pkg::*;
(
    input  aes_byte_t i_byte,
    output aes_byte_t o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_byte)
            8'h00: o_byte = 8'h52; 8'h01: o_byte = 8'h09; 8'h02: o_byte = 8'h6a; 8'h03: o_byte = 8'hd5;
            8'h04: o_byte = 8'h30; 8'h05: o_byte = 8'h36; 8'h06: o_byte = 8'ha5; 8'h07: o_byte = 8'h38;
            8'h08: o_byte = 8'hbf; 8'h09: o_byte = 8'h40; 8'h0a: o_byte = 8'ha3; 8'h0b: o_byte = 8'h9e;
            8'h0c: o_byte = 8'h81; 8'h0d: o_byte = 8'hf3; 8'h0e: o_byte = 8'hd7; 8'h0f: o_byte = 8'hfb;
            8'h10: o_byte = 8'h7c; 8'h11: o_byte = 8'he3; 8'h12: o_byte = 8'h39; 8'h13: o_byte = 8'h82;
            8'h14: o_byte = 8'h9b; 8'h15: o_byte = 8'h2f; 8'h16: o_byte = 8'hff; 8'h17: o_byte = 8'h87;
            8'h18: o_byte = 8'h34; 8'h19: o_byte = 8'h8e; 8'h1a: o_byte = 8'h43; 8'h1b: o_byte = 8'h44;
            8'h1c: o_byte = 8'hc4; 8'h1d: o_byte = 8'hde; 8'h1e: o_byte = 8'he9; 8'h1f: o_byte = 8'hcb;
            8'h20: o_byte = 8'h54; 8'h21: o_byte = 8'h7b; 8'h22: o_byte = 8'h94; 8'h23: o_byte = 8'h32;
            8'h24: o_byte = 8'ha6; 8'h25: o_byte = 8'hc2; 8'h26: o_byte = 8'h23; 8'h27: o_byte = 8'h3d;
            8'h28: o_byte = 8'hee; 8'h29: o_byte = 8'h4c; 8'h2a: o_byte = 8'h95; 8'h2b: o_byte = 8'h0b;
            8'h2c: o_byte = 8'h42; 8'h2d: o_byte = 8'hfa; 8'h2e: o_byte = 8'hc3; 8'h2f: o_byte = 8'h4e;
            8'h30: o_byte = 8'h08; 8'h31: o_byte = 8'h2e; 8'h32: o_byte = 8'ha1; 8'h33: o_byte = 8'h66;
            8'h34: o_byte = 8'h28; 8'h35: o_byte = 8'hd9; 8'h36: o_byte = 8'h24; 8'h37: o_byte = 8'hb2;
            8'h38: o_byte = 8'h76; 8'h39: o_byte = 8'h5b; 8'h3a: o_byte = 8'ha2; 8'h3b: o_byte = 8'h49;
            8'h3c: o_byte = 8'h6d; 8'h3d: o_byte = 8'h8b; 8'h3e: o_byte = 8'hd1; 8'h3f: o_byte = 8'h25;
            8'h40: o_byte = 8'h72; 8'h41: o_byte = 8'hf8; 8'h42: o_byte = 8'hf6; 8'h43: o_byte = 8'h64;
            8'h44: o_byte = 8'h86; 8'h45: o_byte = 8'h68; 8'h46: o_byte = 8'h98; 8'h47: o_byte = 8'h16;
            8'h48: o_byte = 8'hd4; 8'h49: o_byte = 8'ha4; 8'h4a: o_byte = 8'h5c; 8'h4b: o_byte = 8'hcc;
            8'h4c: o_byte = 8'h5d; 8'h4d: o_byte = 8'h65; 8'h4e: o_byte = 8'hb6; 8'h4f: o_byte = 8'h92;
            8'h50: o_byte = 8'h6c; 8'h51: o_byte = 8'h70; 8'h52: o_byte = 8'h48; 8'h53: o_byte = 8'h50;
            8'h54: o_byte = 8'hfd; 8'h55: o_byte = 8'hed; 8'h56: o_byte = 8'hb9; 8'h57: o_byte = 8'hda;
            8'h58: o_byte = 8'h5e; 8'h59: o_byte = 8'h15; 8'h5a: o_byte = 8'h46; 8'h5b: o_byte = 8'h57;
            8'h5c: o_byte = 8'ha7; 8'h5d: o_byte = 8'h8d; 8'h5e: o_byte = 8'h9d; 8'h5f: o_byte = 8'h84;
            8'h60: o_byte = 8'h90; 8'h61: o_byte = 8'hd8; 8'h62: o_byte = 8'hab; 8'h63: o_byte = 8'h00;
            8'h64: o_byte = 8'h8c; 8'h65: o_byte = 8'hbc; 8'h66: o_byte = 8'hd3; 8'h67: o_byte = 8'h0a;
            8'h68: o_byte = 8'hf7; 8'h69: o_byte = 8'he4; 8'h6a: o_byte = 8'h58; 8'h6b: o_byte = 8'h05;
            8'h6c: o_byte = 8'hb8; 8'h6d: o_byte = 8'hb3; 8'h6e: o_byte = 8'h45; 8'h6f: o_byte = 8'h06;
            8'h70: o_byte = 8'hd0; 8'h71: o_byte = 8'h2c; 8'h72: o_byte = 8'h1e; 8'h73: o_byte = 8'h8f;
            8'h74: o_byte = 8'hca; 8'h75: o_byte = 8'h3f; 8'h76: o_byte = 8'h0f; 8'h77: o_byte = 8'h02;
            8'h78: o_byte = 8'hc1; 8'h79: o_byte = 8'haf; 8'h7a: o_byte = 8'hbd; 8'h7b: o_byte = 8'h03;
            8'h7c: o_byte = 8'h01; 8'h7d: o_byte = 8'h13; 8'h7e: o_byte = 8'h8a; 8'h7f: o_byte = 8'h6b;
            8'h80: o_byte = 8'h3a; 8'h81: o_byte = 8'h91; 8'h82: o_byte = 8'h11; 8'h83: o_byte = 8'h41;
            8'h84: o_byte = 8'h4f; 8'h85: o_byte = 8'h67; 8'h86: o_byte = 8'hdc; 8'h87: o_byte = 8'hea;
            8'h88: o_byte = 8'h97; 8'h89: o_byte = 8'hf2; 8'h8a: o_byte = 8'hcf; 8'h8b: o_byte = 8'hce;
            8'h8c: o_byte = 8'hf0; 8'h8d: o_byte = 8'hb4; 8'h8e: o_byte = 8'he6; 8'h8f: o_byte = 8'h73;
            8'h90: o_byte = 8'h96; 8'h91: o_byte = 8'hac; 8'h92: o_byte = 8'h74; 8'h93: o_byte = 8'h22;
            8'h94: o_byte = 8'he7; 8'h95: o_byte = 8'had; 8'h96: o_byte = 8'h35; 8'h97: o_byte = 8'h85;
            8'h98: o_byte = 8'he2; 8'h99: o_byte = 8'hf9; 8'h9a: o_byte = 8'h37; 8'h9b: o_byte = 8'he8;
            8'h9c: o_byte = 8'h1c; 8'h9d: o_byte = 8'h75; 8'h9e: o_byte = 8'hdf; 8'h9f: o_byte = 8'h6e;
            8'ha0: o_byte = 8'h47; 8'ha1: o_byte = 8'hf1; 8'ha2: o_byte = 8'h1a; 8'ha3: o_byte = 8'h71;
            8'ha4: o_byte = 8'h1d; 8'ha5: o_byte = 8'h29; 8'ha6: o_byte = 8'hc5; 8'ha7: o_byte = 8'h89;
            8'ha8: o_byte = 8'h6f; 8'ha9: o_byte = 8'hb7; 8'haa: o_byte = 8'h62; 8'hab: o_byte = 8'h0e;
            8'hac: o_byte = 8'haa; 8'had: o_byte = 8'h18; 8'hae: o_byte = 8'hbe; 8'haf: o_byte = 8'h1b;
            8'hb0: o_byte = 8'hfc; 8'hb1: o_byte = 8'h56; 8'hb2: o_byte = 8'h3e; 8'hb3: o_byte = 8'h4b;
            8'hb4: o_byte = 8'hc6; 8'hb5: o_byte = 8'hd2; 8'hb6: o_byte = 8'h79; 8'hb7: o_byte = 8'h20;
            8'hb8: o_byte = 8'h9a; 8'hb9: o_byte = 8'hdb; 8'hba: o_byte = 8'hc0; 8'hbb: o_byte = 8'hfe;
            8'hbc: o_byte = 8'h78; 8'hbd: o_byte = 8'hcd; 8'hbe: o_byte = 8'h5a; 8'hbf: o_byte = 8'hf4;
            8'hc0: o_byte = 8'h1f; 8'hc1: o_byte = 8'hdd; 8'hc2: o_byte = 8'ha8; 8'hc3: o_byte = 8'h33;
            8'hc4: o_byte = 8'h88; 8'hc5: o_byte = 8'h07; 8'hc6: o_byte = 8'hc7; 8'hc7: o_byte = 8'h31;
            8'hc8: o_byte = 8'hb1; 8'hc9: o_byte = 8'h12; 8'hca: o_byte = 8'h10; 8'hcb: o_byte = 8'h59;
            8'hcc: o_byte = 8'h27; 8'hcd: o_byte = 8'h80; 8'hce: o_byte = 8'hec; 8'hcf: o_byte = 8'h5f;
            8'hd0: o_byte = 8'h60; 8'hd1: o_byte = 8'h51; 8'hd2: o_byte = 8'h7f; 8'hd3: o_byte = 8'ha9;
            8'hd4: o_byte = 8'h19; 8'hd5: o_byte = 8'hb5; 8'hd6: o_byte = 8'h4a; 8'hd7: o_byte = 8'h0d;
            8'hd8: o_byte = 8'h2d; 8'hd9: o_byte = 8'he5; 8'hda: o_byte = 8'h7a; 8'hdb: o_byte = 8'h9f;
            8'hdc: o_byte = 8'h93; 8'hdd: o_byte = 8'hc9; 8'hde: o_byte = 8'h9c; 8'hdf: o_byte = 8'hef;
            8'he0: o_byte = 8'ha0; 8'he1: o_byte = 8'he0; 8'he2: o_byte = 8'h3b; 8'he3: o_byte = 8'h4d;
            8'he4: o_byte = 8'hae; 8'he5: o_byte = 8'h2a; 8'he6: o_byte = 8'hf5; 8'he7: o_byte = 8'hb0;
            8'he8: o_byte = 8'hc8; 8'he9: o_byte = 8'heb; 8'hea: o_byte = 8'hbb; 8'heb: o_byte = 8'h3c;
            8'hec: o_byte = 8'h83; 8'hed: o_byte = 8'h53; 8'hee: o_byte = 8'h99; 8'hef: o_byte = 8'h61;
            8'hf0: o_byte = 8'h17; 8'hf1: o_byte = 8'h2b; 8'hf2: o_byte = 8'h04; 8'hf3: o_byte = 8'h7e;
            8'hf4: o_byte = 8'hba; 8'hf5: o_byte = 8'h77; 8'hf6: o_byte = 8'hd6; 8'hf7: o_byte = 8'h26;
            8'hf8: o_byte = 8'he1; 8'hf9: o_byte = 8'h69; 8'hfa: o_byte = 8'h14; 8'hfb: o_byte = 8'h63;
            8'hfc: o_byte = 8'h55; 8'hfd: o_byte = 8'h21; 8'hfe: o_byte = 8'h0c; 8'hff: o_byte = 8'h7d;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
//==============================================================================
// Module   : inv_sub_bytes_seq
// Brief    : Iterative AES InvSubBytes, BYTES_PER_CYCLE bytes per clock through
//            a shared inv_sbox bank. Build option: INV_SUB_BYTES_ZEROIZE_EN
//            clears the state register when the result is handed off.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int c_num_groups = NUM_STATE_BYTES / BYTES_PER_CYCLE;
    localparam int c_cnt_w      = (c_num_groups > 1) ? $clog2(c_num_groups) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_num_groups - 1);

    generate
        if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
            BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bpc_illegal
            $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    fsm_state_t         r_fsm;
    logic [c_cnt_w-1:0] r_cnt;
    aes_state_t         r_state;

    logic [3:0] w_group_base;
    logic [3:0] w_idx      [BYTES_PER_CYCLE];
    aes_byte_t  w_sbox_in  [BYTES_PER_CYCLE];
    aes_byte_t  w_sbox_out [BYTES_PER_CYCLE];
    aes_state_t w_next_state;

    assign w_group_base = 4'(r_cnt * BYTES_PER_CYCLE);

    generate
        for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
            assign w_idx[g]     = w_group_base + 4'(g);
            assign w_sbox_in[g] = r_state[byte_slice(w_idx[g]) +: 8];

            inv_sbox u_inv_sbox (
                .i_byte (w_sbox_in[g]),
                .o_byte (w_sbox_out[g])
            );
        end
    endgenerate

    // Only the current group is rewritten; the other bytes pass through.
    always_comb begin
        w_next_state = r_state;
        for (int b = 0; b < BYTES_PER_CYCLE; b++) begin
            w_next_state[byte_slice(w_idx[b]) +: 8] = w_sbox_out[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= c_st_idle;
            r_cnt   <= '0;
            r_state <= '0;
        end else begin
            case (r_fsm)
                c_st_idle: begin
                    if (in_valid) begin
                        r_state <= in_data;
                        r_cnt   <= '0;
                        r_fsm   <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    r_state <= w_next_state;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_fsm <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_fsm <= c_st_idle;
`ifdef INV_SUB_BYTES_ZEROIZE_EN
                        r_state <= '0;
`endif
                    end
                end
                default: r_fsm <= c_st_idle;
            endcase
        end
    end

    assign in_ready  = (r_fsm == c_st_idle);
    assign out_valid = (r_fsm == c_st_done);
    assign out_data  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_inv_sub_bytes_seq.sv
//==============================================================================
// Module   : tb_inv_sub_bytes_seq
// Brief    : Self-checking bench for inv_sub_bytes_seq across all legal widths;
//            reference inverse S-box is derived from GF(2^8) arithmetic.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inv_sub_bytes_seq;

    localparam int c_n = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [0:127]   in_data;
    logic [c_n-1:0] in_valid;
    logic [c_n-1:0] in_ready;
    logic [c_n-1:0] out_valid;
    logic [c_n-1:0] out_ready;
    logic [0:127]   out_data [c_n];

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < c_n; i++) begin : g_dut
            localparam int c_bpc = (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 2 : (i == 3) ? 8 : 16;
            inv_sub_bytes_seq #(.BYTES_PER_CYCLE(c_bpc)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_data   (in_data),
                .in_valid  (in_valid[i]),
                .in_ready  (in_ready[i]),
                .out_data  (out_data[i]),
                .out_valid (out_valid[i]),
                .out_ready (out_ready[i])
            );
        end
    endgenerate

    function automatic int bpc(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 2 : (i == 3) ? 8 : 16;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box = affine(GF inverse); invert it by table lookup.
    task automatic build_table();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [0:127] ref_inv_sub(input logic [0:127] s);
        logic [0:127] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[s[8*k +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic complete(input int idx, input logic [0:127] data, input int hold,
                            input string tag, output logic [0:127] got);
        int lat;
        logic [0:127] exp;
        exp = ref_inv_sub(data);
        @(negedge clk);
        in_data       = data;
        in_valid[idx] = 1'b1;
        check({tag, " in_ready idle"}, 128'(in_ready[idx]), 128'(1'b1));
        @(negedge clk);
        in_valid[idx] = 1'b0;
        check({tag, " in_ready busy"}, 128'(in_ready[idx]), 128'(1'b0));
        lat = 0;
        while (out_valid[idx] !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(16 / bpc(idx)));
        got = out_data[idx];
        check({tag, " out_data"}, got, exp);
        repeat (hold) @(negedge clk);
        check({tag, " held out_valid"}, 128'(out_valid[idx]), 128'(1'b1));
        check({tag, " held out_data"}, out_data[idx], exp);
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        check({tag, " release out_valid"}, 128'(out_valid[idx]), 128'(1'b0));
        check({tag, " release in_ready"}, 128'(in_ready[idx]), 128'(1'b1));
`ifdef INV_SUB_BYTES_ZEROIZE_EN
        check({tag, " idle zeroized"}, out_data[idx], 128'h0);
`else
        check({tag, " idle retains"}, out_data[idx], exp);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] all63, t2_in, t2_exp, zero, got, rnd, other;
        all63  = {16{8'h63}};
        t2_in  = 128'hD47C16ED_63636363_63636363_63636363;
        t2_exp = 128'h1901FF53_00000000_00000000_00000000;
        zero   = '0;

        build_table();
        rst = 1'b1; in_valid = '0; out_ready = '0; in_data = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < c_n; i++) begin
            check($sformatf("reset out_valid[%0d]", i), 128'(out_valid[i]), 128'(1'b0));
            check($sformatf("reset in_ready[%0d]", i), 128'(in_ready[i]), 128'(1'b1));
            check($sformatf("reset out_data[%0d]", i), out_data[i], zero);
        end
        rst = 1'b0;

        // All-0x63 state and byte-ordering vector on BPC=4.
        complete(0, all63, 0, "t1 all63", got);
        check("t1 literal", got, zero);
        complete(0, t2_in, 0, "t2 order", got);
        check("t2 literal", got, t2_exp);

        // Backpressure: result held, new input refused while DONE.
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        in_data = rnd; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        other = ~rnd;
        for (int c = 0; c < 10; c++) begin
            check("t3 hold out_valid", 128'(out_valid[0]), 128'(1'b1));
            check("t3 hold in_ready", 128'(in_ready[0]), 128'(1'b0));
            check("t3 hold out_data", out_data[0], ref_inv_sub(rnd));
            in_data = other; in_valid[0] = 1'b1;
            @(negedge clk);
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("t3 release out_valid", 128'(out_valid[0]), 128'(1'b0));
        check("t3 release in_ready", 128'(in_ready[0]), 128'(1'b1));

        // Reset in the middle of BUSY (counter at 2) discards the partial state.
        @(negedge clk);
        in_data = all63; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4 rst out_valid", 128'(out_valid[0]), 128'(1'b0));
        check("t4 rst in_ready", 128'(in_ready[0]), 128'(1'b1));
        check("t4 rst out_data", out_data[0], zero);
        complete(0, all63, 0, "t4 after rst", got);
        check("t4 literal", got, zero);

        // Width sweep on the same directed vectors.
        for (int i = 1; i < c_n; i++) begin
            complete(i, all63, 1, $sformatf("t5 bpc%0d all63", bpc(i)), got);
            check($sformatf("t5 bpc%0d literal1", bpc(i)), got, zero);
            complete(i, t2_in, 0, $sformatf("t5 bpc%0d order", bpc(i)), got);
            check($sformatf("t5 bpc%0d literal2", bpc(i)), got, t2_exp);
        end

        // Exhaustive byte sweep: state j carries byte values 16j..16j+15.
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 16; k++) rnd[8*k +: 8] = 8'(16 * j + k);
            complete(j % c_n, rnd, 0, $sformatf("sweep %0d", j), got);
        end

        // Random states, random instance, random backpressure.
        for (int n = 0; n < 30; n++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            complete(int'($urandom_range(0, c_n - 1)), rnd, int'($urandom_range(0, 3)),
                     $sformatf("rand %0d", n), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
